// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : instr_issuer
// Purpose  : Program buffer and sequencer feeding instrword/newinstr to the CPU,
//            one strobe per word followed by a fixed hold window.
//            Optional feature macro: INSTR_ISSUER_SINGLE_STEP_EN (step_mode/step).
// Revision : 1.0 - initial release
// ============================================================================
module instr_issuer #(
    parameter int DEPTH            = 64,
    parameter int ADDR_W           = 6,
    parameter int CYCLES_PER_INSTR = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              stop,
`ifdef INSTR_ISSUER_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [31:0]       instrword,
    output logic              newinstr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam int c_CNT_W      = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
    localparam int c_CNT_LOAD_I = CYCLES_PER_INSTR - 1;
    localparam int c_ONE_I      = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_LOAD_I[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_ONE_I[c_CNT_W-1:0];
    localparam logic [ADDR_W:0]    c_LEN_ONE   = c_ONE_I[ADDR_W:0];
    localparam logic [ADDR_W:0]    c_DEPTH_LEN = DEPTH[ADDR_W:0];

    // LAUNCH is the single idle-looking cycle that inspects the freshly latched length
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_ISSUE  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [31:0]         r_mem [DEPTH];
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     w_len_n;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_n;
    logic                r_stop_pend;
    logic                w_stop_n;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_n;
    logic [31:0]         r_instrword;
    logic [31:0]         w_instr_n;
    logic                r_newinstr;
    logic                w_newinstr_n;
    logic                r_busy;
    logic                r_done;
    logic                w_done_n;
    logic                w_load_ok;
    logic                w_advance;
    logic [ADDR_W:0]     w_len_clamp;
    logic [ADDR_W:0]     w_pc_inc;

    assign w_load_ok   = load_en && (r_state == S_IDLE || r_state == S_LAUNCH)
                         && ({1'b0, load_addr} < c_DEPTH_LEN);
    assign w_len_clamp = (prog_len > c_DEPTH_LEN) ? c_DEPTH_LEN : prog_len;
    assign w_pc_inc    = {1'b0, r_pc} + c_LEN_ONE;

`ifdef INSTR_ISSUER_SINGLE_STEP_EN
    assign w_advance = !step_mode || step;
`else
    assign w_advance = 1'b1;
`endif

    // Program buffer survives reset so a host can reload-free replay after reset
    always_ff @(posedge clock) begin
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_len_n      = r_len;
        w_cnt_n      = r_cnt;
        w_stop_n     = r_stop_pend;
        w_pc_n       = r_pc;
        w_instr_n    = r_instrword;
        w_newinstr_n = 1'b0;
        w_done_n     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !load_en && !stop) begin
                    w_len_n   = w_len_clamp;
                    w_state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (r_len == '0) begin
                    w_done_n  = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_pc_n       = '0;
                    w_instr_n    = r_mem[0];
                    w_newinstr_n = 1'b1;
                    w_state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_stop_n  = r_stop_pend | stop;
                w_cnt_n   = c_CNT_LOAD;
                w_state_n = S_WAIT;
            end
            S_WAIT: begin
                w_stop_n = r_stop_pend | stop;
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - c_CNT_ONE;
                end else if (w_stop_n) begin
                    // a pending stop ends the run even when waiting for a step
                    w_done_n  = 1'b1;
                    w_stop_n  = 1'b0;
                    w_state_n = S_IDLE;
                end else if (w_advance) begin
                    if (w_pc_inc == r_len) begin
                        w_done_n  = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_pc_n       = w_pc_inc[ADDR_W-1:0];
                        w_instr_n    = r_mem[w_pc_inc[ADDR_W-1:0]];
                        w_newinstr_n = 1'b1;
                        w_state_n    = S_ISSUE;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
            r_pc        <= '0;
            r_instrword <= '0;
            r_newinstr  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_len       <= w_len_n;
            r_cnt       <= w_cnt_n;
            r_stop_pend <= w_stop_n;
            r_pc        <= w_pc_n;
            r_instrword <= w_instr_n;
            r_newinstr  <= w_newinstr_n;
            r_busy      <= (w_state_n == S_ISSUE) || (w_state_n == S_WAIT);
            r_done      <= w_done_n;
        end
    end

    assign instrword = r_instrword;
    assign newinstr  = r_newinstr;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
